// File: rtl/ones_stream_gen_pkg.sv
// Shared types for the ones stream generator: FSM state and pattern mode.
package ones_stream_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    MODE_PACKED = 1'b0,
    MODE_SPREAD = 1'b1
  } mode_e;

endpackage

// File: rtl/ones_stream_bit.sv
// Next-bit decision for one pattern beat: packed (ones first) or spread
// (Bresenham-style accumulator that spaces cnt ones over DATA_WIDTH beats).
module ones_stream_bit
  import ones_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CW         = $clog2(DATA_WIDTH) + 1,
  parameter int AW         = CW + 1
) (
  input  mode_e          mode,
  input  logic [CW-1:0]  idx,
  input  logic [AW-1:0]  acc,
  input  logic [CW-1:0]  cnt,
  output logic           nxt_bit,
  output logic [AW-1:0]  acc_nxt
);

  localparam logic [AW-1:0] DW_A = AW'(DATA_WIDTH);

  logic [AW-1:0] sum;

  always_comb begin
    nxt_bit = 1'b0;
    acc_nxt = acc;
    sum     = acc + AW'(cnt);
    if (mode == MODE_SPREAD) begin
      // acc stays below DATA_WIDTH, so sum never exceeds 2*DATA_WIDTH-1
      nxt_bit = (sum >= DW_A);
      acc_nxt = nxt_bit ? (sum - DW_A) : sum;
    end else begin
      nxt_bit = (idx < cnt);
    end
  end

endmodule

// File: rtl/ones_stream_gen.sv
// Turns a population count into a DATA_WIDTH-beat serial bit pattern.
// Optional word collection output enabled by ONES_STREAM_GEN_WORD_EN.
module ones_stream_gen
  import ones_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(DATA_WIDTH):0]   din,
  input  logic                          din_mode,
  input  logic                          din_valid,
  output logic                          din_ready,
  output logic                          dout,
  output logic                          dout_valid,
  output logic                          dout_last,
  input  logic                          dout_ready
`ifdef ONES_STREAM_GEN_WORD_EN
  , output logic [DATA_WIDTH-1:0]       word_out
  , output logic                        word_valid
`endif
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam int AW = CW + 1;
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(DATA_WIDTH - 1);

  state_e        state_q, state_d;
  mode_e         mode_q;
  logic [CW-1:0] idx_q, cnt_q;
  logic [AW-1:0] acc_q, acc_nxt;
  logic          nxt_bit;
  logic          is_last, take_cnt, beat;

  assign is_last  = (idx_q == LAST_C);
  assign take_cnt = (state_q == IDLE) && din_valid;
  assign beat     = (state_q == RUN) && dout_ready;

  ones_stream_bit #(
    .DATA_WIDTH (DATA_WIDTH),
    .CW         (CW),
    .AW         (AW)
  ) u_bit (
    .mode    (mode_q),
    .idx     (idx_q),
    .acc     (acc_q),
    .cnt     (cnt_q),
    .nxt_bit (nxt_bit),
    .acc_nxt (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (din_valid)          state_d = RUN;
      RUN:     if (dout_ready && is_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, never on dout_ready
  always_comb begin
    din_ready  = (state_q == IDLE);
    dout_valid = (state_q == RUN);
    dout       = dout_valid & nxt_bit;
    dout_last  = dout_valid & is_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      mode_q <= MODE_PACKED;
    end else if (take_cnt) begin
      idx_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= (din > DW_C) ? DW_C : din;
      mode_q <= mode_e'(din_mode);
    end else if (beat) begin
      idx_q  <= idx_q + 1'b1;
      acc_q  <= acc_nxt;
    end
  end

`ifdef ONES_STREAM_GEN_WORD_EN
  // Bits gather in col_q so word_out stays stable until a pattern completes
  logic [DATA_WIDTH-1:0] col_q, col_set;

  assign col_set = col_q | (DATA_WIDTH'(nxt_bit) << idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (take_cnt) begin
        col_q <= '0;
      end else if (beat) begin
        col_q <= col_set;
        if (is_last) begin
          word_out   <= col_set;
          word_valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ones_stream_gen.sv
// Scoreboard bench for ones_stream_gen: expected beats are queued from an
// independent floor-based pattern model and popped as beats are accepted.
module tb_ones_stream_gen;

  localparam int DW = 16;
  localparam int CW = $clog2(DW) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] din = '0;
  logic          din_mode = 1'b0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic          dout, dout_valid, dout_last;
  logic          dout_ready = 1'b0;
`ifdef ONES_STREAM_GEN_WORD_EN
  logic [DW-1:0] word_out;
  logic          word_valid;
`endif

  int vec  = 0;
  int miss = 0;

  typedef struct packed {
    logic b;
    logic last;
  } beat_t;
  beat_t exp_q[$];

  ones_stream_gen #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_mode   (din_mode),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
`ifdef ONES_STREAM_GEN_WORD_EN
    , .word_out   (word_out)
    , .word_valid (word_valid)
`endif
  );

  always #5 clk = ~clk;

  // Bit i of a spread pattern is 1 where floor(k*cnt/DW) steps up
  function automatic logic model_bit(input int cnt, input int mode, input int i);
    if (mode == 0) return (i < cnt);
    return (((i + 1) * cnt) / DW) > ((i * cnt) / DW);
  endfunction

  task automatic run_pattern(input int din_v, input int mode_v, input bit stall,
                             input int abort_at, input string name);
    int cnt, beats, ones, cyc;
    logic [DW-1:0] exp_word;
    logic prev_stall, prev_bit, prev_last;
    bit done;
    beat_t e;
    cnt = (din_v > DW) ? DW : din_v;
    exp_word = '0;
    for (int i = 0; i < DW; i++) begin
      exp_word[i] = model_bit(cnt, mode_v, i);
      exp_q.push_back({model_bit(cnt, mode_v, i), 1'(i == DW - 1)});
    end
    cyc = 0;
    while (!din_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    vec++;
    if (din_ready !== 1'b1) begin
      $display("FAIL %s idle_wait: din_ready=%b expected 1", name, din_ready);
      miss++;
    end
    din = din_v[CW-1:0]; din_mode = mode_v[0]; din_valid = 1'b1; dout_ready = 1'b0;
    @(posedge clk); #1;
    din_valid = 1'b0;
    vec++;
    if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin
      $display("FAIL %s first_beat: dout_valid=%b din_ready=%b expected 1/0",
               name, dout_valid, din_ready);
      miss++;
    end
    beats = 0; ones = 0; prev_stall = 0; prev_bit = 0; prev_last = 0; done = 0; cyc = 0;
    while (!done && cyc < 400) begin
      if (prev_stall) begin
        vec++;
        if (dout !== prev_bit || dout_last !== prev_last) begin
          $display("FAIL %s stall_hold: dout=%b last=%b expected %b/%b",
                   name, dout, dout_last, prev_bit, prev_last);
          miss++;
        end
      end
      if (abort_at >= 0 && beats == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vec++;
        if (dout_valid !== 1'b0 || din_ready !== 1'b1 || dout_last !== 1'b0) begin
          $display("FAIL %s abort: dout_valid=%b din_ready=%b dout_last=%b expected 0/1/0",
                   name, dout_valid, din_ready, dout_last);
          miss++;
        end
        exp_q.delete();
        return;
      end
      dout_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && beats == 4) begin
        din = 5'd16; din_valid = 1'b1;
        vec++;
        if (din_ready !== 1'b0) begin
          $display("FAIL %s run_ignore: din_ready=%b expected 0", name, din_ready);
          miss++;
        end
      end
      if (stall && beats >= 8) din_valid = 1'b0;
      if (dout_valid && dout_ready) begin
        e = exp_q.pop_front();
        vec++;
        if (dout !== e.b || dout_last !== e.last) begin
          $display("FAIL %s beat%0d: dout=%b last=%b expected %b/%b",
                   name, beats, dout, dout_last, e.b, e.last);
          miss++;
        end
        ones += int'(dout);
        beats++;
        if (e.last) done = 1;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_bit   = dout;
      prev_last  = dout_last;
      @(posedge clk); #1;
      cyc++;
    end
    din_valid = 1'b0;
    if (!done) begin
      vec++; miss++;
      $display("FAIL %s timeout: beats=%0d expected %0d", name, beats, DW);
      exp_q.delete();
      return;
    end
    vec++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0) begin
      $display("FAIL %s after_last: din_ready=%b dout_valid=%b expected 1/0",
               name, din_ready, dout_valid);
      miss++;
    end
    vec++;
    if (ones != cnt || exp_q.size() != 0) begin
      $display("FAIL %s ones: got %0d expected %0d (leftover %0d)", name, ones, cnt, exp_q.size());
      miss++;
    end
`ifdef ONES_STREAM_GEN_WORD_EN
    vec++;
    if (word_valid !== 1'b1 || word_out !== exp_word) begin
      $display("FAIL %s word: valid=%b word=%h expected 1/%h", name, word_valid, word_out, exp_word);
      miss++;
    end
    @(posedge clk); #1;
    vec++;
    if (word_valid !== 1'b0 || word_out !== exp_word || $countones(word_out) != cnt) begin
      $display("FAIL %s word_hold: valid=%b word=%h expected 0/%h", name, word_valid, word_out, exp_word);
      miss++;
    end
`else
    if (exp_word === '1) ones = 0;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 1'b0 || dout_last !== 1'b0) begin
      $display("FAIL reset: rdy=%b vld=%b dout=%b last=%b expected 1/0/0/0",
               din_ready, dout_valid, dout, dout_last);
      miss++;
    end
`ifdef ONES_STREAM_GEN_WORD_EN
    vec++;
    if (word_valid !== 1'b0 || word_out !== '0) begin
      $display("FAIL reset_word: valid=%b word=%h expected 0/0", word_valid, word_out);
      miss++;
    end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_packed;
    run_pattern(4, 0, 0, -1, "packed4");
  endtask

  task automatic test_spread;
    run_pattern(4, 1, 0, -1, "spread4");
    run_pattern(5, 1, 0, -1, "spread5");
  endtask

  task automatic test_clamp;
    run_pattern(0, 0, 0, -1, "zero");
    run_pattern(31, 0, 0, -1, "clamp31");
    run_pattern(31, 1, 0, -1, "clamp31s");
  endtask

  task automatic test_stall;
    run_pattern(7, 1, 1, -1, "stall7");
  endtask

  task automatic test_reset_midrun;
    run_pattern(9, 0, 0, 5, "abort");
`ifdef ONES_STREAM_GEN_WORD_EN
    vec++;
    if (word_valid !== 1'b0) begin
      $display("FAIL abort_word: valid=%b expected 0", word_valid);
      miss++;
    end
`endif
    run_pattern(3, 0, 0, -1, "post_abort");
  endtask

  task automatic test_back_to_back;
    run_pattern(12, 1, 0, -1, "b2b_a");
    run_pattern(1, 0, 0, -1, "b2b_b");
  endtask

  initial begin
    test_reset;
    test_packed;
    test_spread;
    test_clamp;
    test_stall;
    test_reset_midrun;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
